// File: rtl/pulpino_crypt_bridge.sv
// Crypto-clock bridge: streams latched key/plaintext words to the PULPino mailbox and
// collects the ciphertext words back. Optional key cache: define CRYPT_BRIDGE_KEY_CACHE_EN.
module pulpino_crypt_bridge #(
    parameter int pKEY_WIDTH  = 128,
    parameter int pPT_WIDTH   = 128,
    parameter int pCT_WIDTH   = 128,
    parameter int pWORD_WIDTH = 32,
    parameter int pTIMEOUT    = 65535
) (
    input  logic                   crypto_clk,
    input  logic                   resetn,
    input  logic                   I_start,
    input  logic [pKEY_WIDTH-1:0]  I_key,
    input  logic [pPT_WIDTH-1:0]   I_textin,
    output logic [pCT_WIDTH-1:0]   O_cipherout,
    output logic                   O_ready,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_timeout,
    output logic                   O_trigger,
    output logic [pWORD_WIDTH-1:0] O_tx_data,
    output logic                   O_tx_valid,
    input  logic                   I_tx_ready,
    input  logic [pWORD_WIDTH-1:0] I_rx_data,
    input  logic                   I_rx_valid,
    output logic                   O_rx_ready
);
    localparam int          cSH       = pKEY_WIDTH + pPT_WIDTH;
    localparam logic [15:0] cKEY_LAST = 16'(pKEY_WIDTH / pWORD_WIDTH - 1);
    localparam logic [15:0] cPT_LAST  = 16'(pPT_WIDTH / pWORD_WIDTH - 1);
    localparam logic [15:0] cCT_LAST  = 16'(pCT_WIDTH / pWORD_WIDTH - 1);
    localparam logic [31:0] cTO_LAST  = 32'(pTIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND_KEY, SEND_PT, WAIT_CT} state_t;

    state_t               r_state;
    logic [cSH-1:0]       r_txShift;
    logic [pCT_WIDTH-1:0] r_coll;
    logic [15:0]          r_wcnt;
    logic [31:0]          r_tcnt;

    logic w_txFire;
    logic w_rxFire;
    logic w_skipKey;
    logic w_startAcc;
    logic w_keyDone;
    logic w_timeoutHit;

    assign w_txFire     = O_tx_valid && I_tx_ready;
    assign w_rxFire     = O_rx_ready && I_rx_valid;
    assign w_startAcc   = (r_state == IDLE) && I_start;
    assign w_keyDone    = (r_state == SEND_KEY) && w_txFire && (r_wcnt == cKEY_LAST);
    assign w_timeoutHit = (r_state == WAIT_CT) && !w_rxFire && (pTIMEOUT != 0) && (r_tcnt == cTO_LAST);
    assign O_tx_data    = r_txShift[cSH-1 -: pWORD_WIDTH];
    assign O_busy       = !O_ready;

`ifdef CRYPT_BRIDGE_KEY_CACHE_EN
    logic [pKEY_WIDTH-1:0] r_cacheKey;
    logic                  r_cacheVld;

    assign w_skipKey = r_cacheVld && (r_cacheKey == I_key);

    // The cached key only becomes valid once every key word has actually been sent.
    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_cacheKey <= '0;
            r_cacheVld <= 1'b0;
        end else if (w_startAcc && !w_skipKey) begin
            r_cacheKey <= I_key;
            r_cacheVld <= 1'b0;
        end else if (w_keyDone) begin
            r_cacheVld <= 1'b1;
        end else if (w_timeoutHit) begin
            r_cacheVld <= 1'b0;
        end
    end
`else
    assign w_skipKey = 1'b0;
`endif

    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_txShift   <= '0;
            r_coll      <= '0;
            r_wcnt      <= '0;
            r_tcnt      <= '0;
            O_cipherout <= '0;
            O_ready     <= 1'b1;
            O_done      <= 1'b0;
            O_timeout   <= 1'b0;
            O_trigger   <= 1'b0;
            O_tx_valid  <= 1'b0;
            O_rx_ready  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (I_start) begin
                        O_ready    <= 1'b0;
                        O_done     <= 1'b0;
                        O_timeout  <= 1'b0;
                        O_tx_valid <= 1'b1;
                        r_wcnt     <= '0;
                        if (w_skipKey) begin
                            r_txShift <= {I_textin, {pKEY_WIDTH{1'b0}}};
                            r_state   <= SEND_PT;
                        end else begin
                            r_txShift <= {I_key, I_textin};
                            r_state   <= SEND_KEY;
                        end
                    end
                end
                SEND_KEY: begin
                    if (w_txFire) begin
                        r_txShift <= r_txShift << pWORD_WIDTH;
                        if (r_wcnt == cKEY_LAST) begin
                            r_wcnt  <= '0;
                            r_state <= SEND_PT;
                        end else begin
                            r_wcnt <= r_wcnt + 16'd1;
                        end
                    end
                end
                SEND_PT: begin
                    if (w_txFire) begin
                        r_txShift <= r_txShift << pWORD_WIDTH;
                        if (r_wcnt == cPT_LAST) begin
                            r_wcnt     <= '0;
                            r_tcnt     <= '0;
                            O_tx_valid <= 1'b0;
                            O_rx_ready <= 1'b1;
                            O_trigger  <= 1'b1;
                            r_state    <= WAIT_CT;
                        end else begin
                            r_wcnt <= r_wcnt + 16'd1;
                        end
                    end
                end
                WAIT_CT: begin
                    // First word received is shifted furthest, ending up most significant.
                    if (w_rxFire) begin
                        r_coll <= {r_coll[pCT_WIDTH-pWORD_WIDTH-1:0], I_rx_data};
                        r_tcnt <= '0;
                        if (r_wcnt == cCT_LAST) begin
                            O_cipherout <= {r_coll[pCT_WIDTH-pWORD_WIDTH-1:0], I_rx_data};
                            O_done      <= 1'b1;
                            O_ready     <= 1'b1;
                            O_rx_ready  <= 1'b0;
                            O_trigger   <= 1'b0;
                            r_wcnt      <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_wcnt <= r_wcnt + 16'd1;
                        end
                    end else if (w_timeoutHit) begin
                        O_timeout  <= 1'b1;
                        O_ready    <= 1'b1;
                        O_rx_ready <= 1'b0;
                        O_trigger  <= 1'b0;
                        r_wcnt     <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
